// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per cycle, ciphertext valid 10 edges after accept.
// Holds the result in DONE until out_ready; a new block is accepted only while idle.
module aes_iter_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] cipher_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       fsm;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [7:0]   rcon;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as inverse (a^254) followed by the affine map; no table storage.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240, inv;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
        a15  = gf_mul(a12, a3);
        a240 = gf_mul(a15, a15);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        inv  = gf_mul(gf_mul(a240, a12), a2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0]  rot_w3, sub_w, k0, k1, k2, k3;
    logic [127:0] next_key;

    always_comb begin
        rot_w3 = {key_reg[23:0], key_reg[31:24]};
        sub_w  = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                  sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])} ^ {rcon, 24'h000000};
        k0 = key_reg[127:96] ^ sub_w;
        k1 = key_reg[95:64]  ^ k0;
        k2 = key_reg[63:32]  ^ k1;
        k3 = key_reg[31:0]   ^ k2;
        next_key = {k0, k1, k2, k3};
    end

    // Byte i lives at [127-8i -: 8]; i = row + 4*col.
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] round_out;

    always_comb begin
        round_out = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(state_reg[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[r+4*c] = sb[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++)
            round_out[127-8*i -: 8] = ((round_cnt == 4'd10) ? sr[i] : mc[i]) ^ next_key[127-8*i -: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            round_cnt  <= 4'd0;
            state_reg  <= '0;
            key_reg    <= '0;
            ciphertext <= '0;
            rcon       <= 8'h01;
        end else begin
            case (fsm)
                IDLE: if (in_valid) begin
                    state_reg <= plaintext ^ cipher_key;
                    key_reg   <= cipher_key;
                    round_cnt <= 4'd1;
                    rcon      <= 8'h01;
                    in_ready  <= 1'b0;
                    busy      <= 1'b1;
                    fsm       <= RUN;
                end
                RUN: begin
                    state_reg <= round_out;
                    key_reg   <= next_key;
                    rcon      <= xtime(rcon);
                    if (round_cnt == 4'd10) begin
                        ciphertext <= round_out;
                        out_valid  <= 1'b1;
                        fsm        <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    round_cnt <= 4'd0;
                    fsm       <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: known FIPS-197 vectors plus random blocks against a table-driven AES model.
module tb_aes_iter_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] cipher_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round_cnt;

    int n_cmp = 0;
    int n_err = 0;

    aes_iter_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .cipher_key(cipher_key), .out_valid(out_valid),
        .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy), .round_cnt(round_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_S1    = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] C1_K1    = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    // GF(2^8) multiply by shift-and-add over the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] x;
        logic [7:0] p;
        p = 8'h00;
        x = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x[7:0];
            x = x << 1;
            if (x[8]) x = x ^ 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [7:0] mix_coef(input int d);
        if (d == 0) return 8'h02;
        if (d == 1) return 8'h03;
        return 8'h01;
    endfunction

    // Full key schedule first, then ten rounds over a byte array.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {SBOX[tmp[23:16]], SBOX[tmp[15:8]], SBOX[tmp[7:0]], SBOX[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = SBOX[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        t[r+4*c] = 8'h00;
                        for (int k = 0; k < 4; k++)
                            t[r+4*c] = t[r+4*c] ^ gmul(s[k+4*c], mix_coef((k - r + 4) % 4));
                    end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Presents one block for one cycle; returns on the negedge after the transfer edge.
    task automatic send(input logic [127:0] p, input logic [127:0] k);
        @(negedge clk);
        plaintext  = p;
        cipher_key = k;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; cipher_key = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (round_cnt !== 4'd0) begin n_err++; $display("FAIL reset_round_cnt: got %0d want 0", round_cnt); end
        n_cmp++; if (ciphertext !== 128'h0) begin n_err++; $display("FAIL reset_ciphertext: got %h want 0", ciphertext); end
        rst = 1'b0;
    endtask

    task automatic test_app_b();
        logic bad;
        bad = 1'b0;
        out_ready = 1'b1;
        send(APPB_PT, APPB_KEY);
        for (int j = 1; j <= 10; j++) begin
            n_cmp++;
            if (round_cnt !== 4'(j) || out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL appb_run_cycle%0d: got cnt=%0d ov=%b busy=%b ir=%b want cnt=%0d ov=0 busy=1 ir=0",
                         j, round_cnt, out_valid, busy, in_ready, j);
            end
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL appb_latency: out_valid=%b at edge 10 want 1", out_valid); end
        n_cmp++; if (ciphertext !== APPB_CT) begin n_err++; $display("FAIL appb_ct: got %h want %h", ciphertext, APPB_CT); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || round_cnt !== 4'd0) begin
            n_err++; $display("FAIL appb_return_idle: got ir=%b ov=%b cnt=%0d want 1 0 0", in_ready, out_valid, round_cnt);
        end
    endtask

    task automatic test_c1();
        int lat;
        out_ready = 1'b1;
        send(C1_PT, C1_KEY);
        @(negedge clk);
        n_cmp++; if (dut.state_reg !== C1_S1) begin n_err++; $display("FAIL c1_round1_state: got %h want %h", dut.state_reg, C1_S1); end
        n_cmp++; if (dut.key_reg !== C1_K1) begin n_err++; $display("FAIL c1_round1_key: got %h want %h", dut.key_reg, C1_K1); end
        wait_out(lat);
        n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL c1_latency: got %0d more edges want 9", lat); end
        n_cmp++; if (ciphertext !== C1_CT) begin n_err++; $display("FAIL c1_ct: got %h want %h", ciphertext, C1_CT); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [127:0] p, k, held;
        int lat;
        p = rand128(); k = rand128();
        out_ready = 1'b0;
        send(p, k);
        wait_out(lat);
        n_cmp++; if (lat !== 10 || ciphertext !== aes_ref(p, k)) begin
            n_err++; $display("FAIL bp_result: got lat=%0d ct=%h want lat=10 ct=%h", lat, ciphertext, aes_ref(p, k));
        end
        held = ciphertext;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; plaintext = rand128(); cipher_key = rand128();
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || ciphertext !== held || in_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold%0d: got ov=%b ct=%h ir=%b want ov=1 ct=%h ir=0", i, out_valid, ciphertext, in_ready, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || round_cnt !== 4'd0) begin
            n_err++; $display("FAIL bp_release: got ir=%b ov=%b busy=%b cnt=%0d want 1 0 0 0", in_ready, out_valid, busy, round_cnt);
        end
    endtask

    task automatic test_ignored_input();
        logic [127:0] p, k;
        int guard, lat;
        p = rand128(); k = rand128();
        out_ready = 1'b1;
        send(p, k);
        guard = 0;
        while (round_cnt !== 4'd4 && guard < 20) begin @(negedge clk); guard++; end
        plaintext = ~p; cipher_key = rand128(); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        plaintext = rand128(); cipher_key = rand128();
        wait_out(lat);
        n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL ign_latency: got %0d more edges want 6", lat); end
        n_cmp++; if (ciphertext !== aes_ref(p, k)) begin n_err++; $display("FAIL ign_ct: got %h want %h", ciphertext, aes_ref(p, k)); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [127:0] p, k;
        int guard, lat, stray;
        p = rand128(); k = rand128();
        out_ready = 1'b0;
        send(p, k);
        guard = 0;
        while (round_cnt !== 4'd6 && guard < 20) begin @(negedge clk); guard++; end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || round_cnt !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_ctrl: got busy=%b cnt=%0d ir=%b ov=%b want 0 0 1 0", busy, round_cnt, in_ready, out_valid);
        end
        n_cmp++; if (dut.state_reg !== 128'h0 || dut.key_reg !== 128'h0 || ciphertext !== 128'h0) begin
            n_err++; $display("FAIL mid_reset_data: got st=%h key=%h ct=%h want zeros", dut.state_reg, dut.key_reg, ciphertext);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stray++;
        end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL mid_reset_no_out: got %0d cycles with out_valid want 0", stray); end
        send(APPB_PT, APPB_KEY);
        wait_out(lat);
        n_cmp++; if (lat !== 10 || ciphertext !== APPB_CT) begin
            n_err++; $display("FAIL mid_reset_appb: got lat=%0d ct=%h want lat=10 ct=%h", lat, ciphertext, APPB_CT);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q [$];
        logic [127:0] p, k, e;
        int cyc, last, sent, got;
        cyc = 0; last = -1; sent = 0; got = 0;
        out_ready = 1'b1;
        while (got < 20 && cyc < 20 * 12 + 60) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                n_cmp++; if (ciphertext !== e) begin n_err++; $display("FAIL b2b_ct%0d: got %h want %h", got, ciphertext, e); end
                got++;
            end
            if (in_ready && sent < 20) begin
                p = rand128(); k = rand128();
                plaintext = p; cipher_key = k; in_valid = 1'b1;
                exp_q.push_back(aes_ref(p, k));
                if (last >= 0) begin
                    n_cmp++; if (cyc - last !== 12) begin n_err++; $display("FAIL b2b_interval%0d: got %0d cycles want 12", sent, cyc - last); end
                end
                last = cyc;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 20) begin n_err++; $display("FAIL b2b_count: got %0d results want 20", got); end
    endtask

    initial begin
        test_reset();
        test_app_b();
        test_c1();
        test_backpressure();
        test_ignored_input();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/aes_iter_ctrl.md
AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

Interface
REQ-001 SHALL have clock port `clk`, input, 1 bit; all state changes occur on its rising edge.
REQ-002 SHALL have reset port `rst`, input, 1 bit; reset is asynchronous and active-high.
REQ-003 SHALL have `in_valid`, input, 1 bit: plaintext and key are presented.
REQ-004 SHALL have `in_ready`, output, 1 bit: the block can accept a new block.
REQ-005 SHALL have `plaintext`, input, 128 bits: bits [127:120] are state byte 0 (FIPS-197 column-major order).
REQ-006 SHALL have `cipher_key`, input, 128 bits: AES-128 key, same byte order as `plaintext`.
REQ-007 SHALL have `out_valid`, output, 1 bit: `ciphertext` is valid.
REQ-008 SHALL have `out_ready`, input, 1 bit: the consumer accepts `ciphertext`.
REQ-009 SHALL have `ciphertext`, output, 128 bits: encryption result.
REQ-010 SHALL have `busy`, output, 1 bit: high in RUN and DONE.
REQ-011 SHALL have `round_cnt`, output, 4 bits: current round number, for debug.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL drive `in_ready`=1 only in IDLE.
- A transfer occurs on an edge where `in_valid`&&`in_ready`.
REQ-014 On an input transfer, the block SHALL:
- load state_reg <= `plaintext` ^ `cipher_key` (initial AddRoundKey);
- load key_reg <= `cipher_key`;
- set `round_cnt`=1 and rcon=8'h01;
- go to RUN.
REQ-015 In RUN, the block SHALL perform exactly one round per cycle:
- compute next_key = KeyExpand(key_reg, rcon), i.e. RotWord, SubWord and rcon XOR on w3, then the w0..w3 chain;
- state_reg <= Round(state_reg, next_key);
- key_reg <= next_key.
REQ-016 Round SHALL be SubBytes -> ShiftRows -> MixColumns -> AddRoundKey for `round_cnt` 1..9.
REQ-017 Round SHALL omit MixColumns when `round_cnt`=10.
REQ-018 rcon SHALL advance by xtime each round: 01,02,04,08,10,20,40,80,1b,36.
- The 80 -> 1b step uses reduction by 8'h1b.
REQ-019 `round_cnt` SHALL increment by 1 per RUN cycle.
- On the edge that completes round 10, the FSM goes to DONE.
- `round_cnt` never wraps past 10.
REQ-020 Latency SHALL be 10 clock edges from the input-transfer edge to the first cycle with `out_valid`=1.
REQ-021 In DONE, the block SHALL drive `out_valid`=1 and `ciphertext`=state_reg.
- Both are held stable until `out_ready`=1.
REQ-022 On an edge in DONE with `out_ready`=1, the block SHALL:
- return to IDLE;
- clear `out_valid`;
- set `round_cnt`=0.
REQ-023 `ciphertext` SHALL retain its last value in IDLE and RUN.
- It is meaningful only while `out_valid`=1.
REQ-024 `in_valid` asserted in RUN or DONE SHALL be ignored.
- There is no queuing and no change to the in-flight block.
REQ-025 Changes on `plaintext`/`cipher_key` after the transfer edge SHALL NOT affect the in-flight result.
REQ-026 `out_ready` asserted outside DONE SHALL have no effect.
REQ-027 Back-to-back throughput SHALL be one block per 12 cycles minimum.
- The cycles are: transfer, 10 rounds, then DONE for one cycle with `out_ready`=1.
- IDLE is re-entered before the next accept.
REQ-028 S-box, ShiftRows and MixColumns logic SHALL be combinational and local to this block.
- No RAM is used.
- Any shared S-box must not add latency.

Reset
REQ-029 Asserting `rst` SHALL immediately force all of the following, regardless of FSM state:
- state IDLE;
- `in_ready`=1, `out_valid`=0, `busy`=0;
- `round_cnt`=0;
- state_reg, key_reg and `ciphertext` = 128'h0;
- rcon=8'h01.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the in-flight block.
- No `out_valid` pulse follows reset release.
REQ-031 After `rst` deasserts, the block SHALL accept a transfer on the first rising edge where `in_valid`=1.

Verification
REQ-032 The bench SHALL cover FIPS-197 App. B:
- pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c.
- Required: `ciphertext`=3925841d02dc09fbdc118597196a0b32, with `out_valid` on the 10th edge after the transfer.
REQ-033 The bench SHALL cover FIPS-197 C.1:
- pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f.
- Required after the first RUN edge: state_reg=89d810e8855ace682d1843d8cb128fe4 and key_reg=d6aa74fdd2af72fadaa678f1d6ab76fe.
- Required final: `ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-034 The bench SHALL cover backpressure:
- Stimulus: hold `out_ready`=0 for 5 cycles in DONE.
- Required: `out_valid` and `ciphertext` are stable throughout, `in_ready`=0, and IDLE is reached on the edge where `out_ready`=1.
REQ-035 The bench SHALL cover ignored input:
- Stimulus: pulse `in_valid` with different data during RUN round 4.
- Required: the result is still the original vector's ciphertext.
REQ-036 The bench SHALL cover reset mid-operation:
- Stimulus: assert `rst` asynchronously at `round_cnt`=6.
- Required: `busy`=0 and `round_cnt`=0 immediately, no `out_valid` follows, and the next App. B vector completes correctly.
